// File: rtl/sram_sync_ctrl_if.sv
// Request/response bus for sram_sync_ctrl. With SRAM_SYNC_PARITY_EN defined the bus
// also carries the parity error flag and the write-parity fault-injection input.
interface sram_sync_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
`ifdef SRAM_SYNC_PARITY_EN
    logic                  rsp_err;
    logic                  wr_par_flip;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, wr_par_flip,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, wr_par_flip,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
`endif
endinterface

// File: rtl/sram_sync_ctrl.sv
// Synchronous single-port SRAM with valid/ready request and one-entry response register.
// Memory is swept to zero after reset. Optional even parity per word: SRAM_SYNC_PARITY_EN.
module sram_sync_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    sram_sync_ctrl_if.slave      bus,
    output logic                 o_busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef SRAM_SYNC_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic [WORD_W-1:0]     r_mem [DEPTH];

    logic                  w_req_ready;
    logic                  w_rd_accept;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [WORD_W-1:0]     w_wword;
    logic [WORD_W-1:0]     w_rd_word;

    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

`ifdef SRAM_SYNC_PARITY_EN
    logic                  r_rsp_err;

    function automatic logic f_even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    assign w_rd_word = r_mem[bus.req_addr];

    // State and clear-pointer register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_CLEAR;
            r_ptr   <= {ADDR_WIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next state, handshake and memory write port selection
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_req_ready = 1'b0;
        w_we        = 1'b0;
        w_waddr     = bus.req_addr;
        w_wword     = {WORD_W{1'b0}};
        w_rd_accept = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                // Sweep writes an all-zero word, which also carries parity 0
                w_we      = 1'b1;
                w_waddr   = r_ptr;
                w_ptr_nxt = r_ptr + ADDR_ONE;
                if (r_ptr == ADDR_LAST) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_READY: begin
                w_req_ready = !r_rsp_valid || bus.rsp_ready;
                w_we        = w_req_ready && bus.req_valid && bus.req_write;
                w_rd_accept = w_req_ready && bus.req_valid && !bus.req_write;
`ifdef SRAM_SYNC_PARITY_EN
                w_wword     = {f_even_parity(bus.req_wdata) ^ bus.wr_par_flip, bus.req_wdata};
`else
                w_wword     = bus.req_wdata;
`endif
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Storage array write port (no reset so it maps onto RAM)
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wword;
        end
    end

    // Response register: load on accepted read, drain on rsp_ready, data holds otherwise
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
`ifdef SRAM_SYNC_PARITY_EN
            r_rsp_err   <= 1'b0;
`endif
        end else if (w_rd_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rd_word[DATA_WIDTH-1:0];
`ifdef SRAM_SYNC_PARITY_EN
            r_rsp_err   <= w_rd_word[DATA_WIDTH] ^ f_even_parity(w_rd_word[DATA_WIDTH-1:0]);
`endif
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
`ifdef SRAM_SYNC_PARITY_EN
    assign bus.rsp_err   = r_rsp_err;
`endif
    assign o_busy        = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_sram_sync_ctrl.sv
// Scoreboard bench for sram_sync_ctrl (ADDR_WIDTH=4, DATA_WIDTH=8); reads push expected
// words into a queue that a monitor pops when a response is consumed.
module tb_sram_sync_ctrl;
    logic       clk;
    logic       rst;
    logic       busy;
    int         n_tests;
    int         n_fail;
    logic [8:0] exp_q [$];
    logic [7:0] model_mem [16];
    logic       model_err [16];
    logic       flip_v;
    logic [8:0] mon_exp;

    sram_sync_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sram_sync_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 8'h00;
            model_err[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    // Release reset on a falling edge and measure the sweep length in cycles
    task automatic release_and_sweep();
        int  cnt;
        logic rdy_seen;
        @(negedge clk);
        rst = 1'b0;
        #1;
        cnt = 0;
        rdy_seen = 1'b0;
        while (busy && cnt < 100) begin
            if (bus.req_ready) rdy_seen = 1'b1;
            cnt++;
            @(negedge clk);
            #1;
        end
        check("sweep_len", cnt, 16);
        check("sweep_ready_low", {31'd0, rdy_seen}, 32'd0);
        check("ready_after_sweep", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d, input logic rdy);
        int t;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rdy;
`ifdef SRAM_SYNC_PARITY_EN
        bus.wr_par_flip = flip_v;
`endif
        #1;
        t = 0;
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.req_ready) begin
            check("req_timeout", 32'd0, 32'd1);
        end else if (wr) begin
            model_mem[a] = d;
            model_err[a] = flip_v;
        end else begin
            exp_q.push_back({model_err[a], model_mem[a]});
        end
    endtask

    task automatic idle(input logic rdy);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.rsp_ready = rdy;
        #1;
    endtask

    // Response monitor: compare each consumed response against the scoreboard head
    always @(negedge clk) begin
        #1;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_data", {24'd0, bus.rsp_rdata}, {24'd0, mon_exp[7:0]});
`ifdef SRAM_SYNC_PARITY_EN
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_exp[8]});
`endif
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        flip_v  = 1'b0;
        rst     = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 4'h0;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b0;
`ifdef SRAM_SYNC_PARITY_EN
        bus.wr_par_flip = 1'b0;
`endif
        model_clear();
        #2;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        release_and_sweep();

        // Every address reads zero after the sweep
        for (int i = 0; i < 16; i++) issue(1'b0, 4'(i), 8'h00, 1'b1);
        idle(1'b1);

        // Write then read the same address on consecutive cycles
        issue(1'b1, 4'd3, 8'hA5, 1'b1);
        issue(1'b0, 4'd3, 8'h00, 1'b1);
        idle(1'b1);
        check("wr_rd_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("wr_rd_data", {24'd0, bus.rsp_rdata}, 32'h000000A5);
        issue(1'b0, 4'd4, 8'h00, 1'b1);
        idle(1'b1);

        // Backpressure: response must hold, then a back-to-back read follows without a bubble
        issue(1'b1, 4'd3, 8'h5A, 1'b1);
        issue(1'b1, 4'd4, 8'h11, 1'b1);
        issue(1'b0, 4'd3, 8'h00, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_data", {24'd0, bus.rsp_rdata}, 32'h0000005A);
            check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
            #1;
        end
        issue(1'b0, 4'd4, 8'h00, 1'b1);
        idle(1'b1);
        check("bp_nobubble_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("bp_nobubble_data", {24'd0, bus.rsp_rdata}, 32'h00000011);

        // Streaming: pattern addr*8'h11, then 16 back-to-back reads
        for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), 8'(i * 17), 1'b1);
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 4'(i), 8'h00, 1'b1);
            if (i > 0) check("stream_valid", {31'd0, bus.rsp_valid}, 32'd1);
        end
        idle(1'b1);
        check("stream_last_valid", {31'd0, bus.rsp_valid}, 32'd1);
        idle(1'b1);

        // Asynchronous reset with a pending response and no clock edge
        issue(1'b1, 4'd5, 8'hFF, 1'b1);
        issue(1'b0, 4'd5, 8'h00, 1'b0);
        idle(1'b0);
        check("pend_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("pend_data", {24'd0, bus.rsp_rdata}, 32'h000000FF);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("async_rst_data", {24'd0, bus.rsp_rdata}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd1);
        model_clear();
        bus.rsp_ready = 1'b1;
        release_and_sweep();
        issue(1'b0, 4'd3, 8'h00, 1'b1);
        idle(1'b1);
        check("post_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);
        idle(1'b1);

`ifdef SRAM_SYNC_PARITY_EN
        flip_v = 1'b1;
        issue(1'b1, 4'd6, 8'h07, 1'b1);
        flip_v = 1'b0;
        issue(1'b0, 4'd6, 8'h00, 1'b1);
        idle(1'b1);
        check("par_flip_err", {31'd0, bus.rsp_err}, 32'd1);
        issue(1'b1, 4'd6, 8'h07, 1'b1);
        issue(1'b0, 4'd6, 8'h00, 1'b1);
        idle(1'b1);
        check("par_ok_err", {31'd0, bus.rsp_err}, 32'd0);
        idle(1'b1);
`endif

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_sync_ctrl.md
Name: sram_sync_ctrl

Overview:
- Parametrised, synchronous, single-port SRAM block with a request/response handshake.
- Successor to the team's 2k x 8 asynchronous active-low-enable SRAM: width and depth are generic, all accesses are clocked, read latency is fixed, and response backpressure is supported.
- After reset, a hardware sweep clears the memory to zero, so no read ever returns X.
- Sits between the lab controllers/FSMs and the storage array; other blocks use it as a scratch or frame buffer.

Parameters:
- DATA_WIDTH, 8, bits per word.
- ADDR_WIDTH, 11, address bits; DEPTH = 2**ADDR_WIDTH words (default 2048).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  read data valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data.
- busy  output  1  high while the init sweep runs.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=1, FSM=CLEAR, clear pointer=0.
- FSM CLEAR:
  - Writes 0 to address ptr every cycle and increments ptr.
  - When ptr==DEPTH-1 is written, the next state is READY; busy drops the same edge.
  - Takes exactly DEPTH cycles after reset deasserts.
  - req_ready=0 throughout.
- FSM READY: req_ready = !rsp_valid || rsp_ready. This is a one-entry output register with no bubble when drained each cycle.
- A request is accepted on a rising edge when req_valid && req_ready.
- Write:
  - mem[req_addr] <= req_wdata at the accepting edge.
  - No response is generated; rsp_valid is unaffected except by its normal drain.
- Read:
  - rsp_rdata <= mem[req_addr] and rsp_valid <= 1 at the accepting edge (latency 1).
  - rsp_rdata holds stable while rsp_valid && !rsp_ready.
- Response drain: rsp_valid clears at an edge where rsp_ready=1 and no new read is accepted. A read accepted in the same cycle keeps rsp_valid=1 with new data.
- Write then read, same address, consecutive cycles: the read returns the new data.
- rsp_rdata keeps its last value when rsp_valid=0; it is not cleared.
- Address is always in range; there is no wrap logic beyond the natural ADDR_WIDTH width.
- Reset asserted mid-operation (any state):
  - Outputs return to reset values immediately (asynchronous).
  - Any pending response is lost.
  - The clear sweep restarts from address 0 after reset deasserts.
- Inputs are ignored while req_ready=0.

Optional Feature:
- Macro: SRAM_SYNC_PARITY_EN.
- Defined:
  - Each word stores DATA_WIDTH+1 bits; the extra bit is even parity of the data, computed on write.
  - The clear sweep writes parity 0.
  - Extra ports:
    - rsp_err (output, 1): registered with rsp_rdata; 1 when stored parity mismatches the recomputed parity; reset 0.
    - wr_par_flip (input, 1): when high during an accepted write, the stored parity bit is inverted (fault injection).
- Not defined: storage is DATA_WIDTH bits; rsp_err and wr_par_flip do not exist; behaviour is otherwise identical.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=8 unless noted):
- Init sweep:
  - Stimulus: pulse reset, then deassert it.
  - Required: busy=1 and req_ready=0 for exactly 16 cycles, then busy=0 and req_ready=1.
  - Then read all 16 addresses; each returns 8'h00.
- Write/read:
  - Stimulus: write 8'hA5 to addr 3, next cycle read addr 3.
  - Required: rsp_valid=1 one edge after the read is accepted, rsp_rdata=8'hA5.
  - Also read addr 4 -> 8'h00.
- Backpressure:
  - Stimulus: hold rsp_ready=0, read addr 3 (holding 8'h5A).
  - Required: rsp_valid=1, rsp_rdata=8'h5A held for 5 cycles, req_ready=0.
  - Stimulus: raise rsp_ready with a back-to-back read of addr 4 (8'h11) presented.
  - Required: 8'h11 appears on the next edge with no bubble.
- Streaming:
  - Stimulus: rsp_ready=1, read addresses 0..15 on consecutive cycles.
  - Required: 16 consecutive rsp_valid cycles, data matching previously written pattern addr*8'h11.
- Reset mid-operation:
  - Stimulus: assert reset while rsp_valid=1 with 8'hFF pending and no clock edge.
  - Required: rsp_valid=0 and rsp_rdata=0 immediately.
  - After release, a 16-cycle sweep runs and addr 3 then reads 8'h00.
- Parity (SRAM_SYNC_PARITY_EN defined):
  - Stimulus: write 8'h07 with wr_par_flip=1, then read.
  - Required: rsp_rdata=8'h07, rsp_err=1.
  - Stimulus: same write with wr_par_flip=0, then read.
  - Required: rsp_err=0.
